// File: rtl/fmpadding_pkg.sv
// rtl/fmpadding_pkg.sv - shared register map, counter types and config bundle for fmpadding_dil
package fmpadding_pkg;

   localparam int XCNT_W = 8;
   localparam int YCNT_W = 8;
   localparam int DCNT_W = 4;
   localparam int ELEM_W = 8;

   typedef enum logic [4:0] {
      ADDR_XON    = 5'd0,
      ADDR_XOFF   = 5'd1,
      ADDR_XEND   = 5'd2,
      ADDR_YON    = 5'd3,
      ADDR_YOFF   = 5'd4,
      ADDR_YEND   = 5'd5,
      ADDR_XDIL   = 5'd6,
      ADDR_YDIL   = 5'd7,
      ADDR_PADVAL = 5'd8
   } addr_e;

   typedef logic [XCNT_W-1:0] xcnt_t;
   typedef logic [YCNT_W-1:0] ycnt_t;
   typedef logic [DCNT_W-1:0] dcnt_t;

   typedef struct packed {
      xcnt_t             xon;
      xcnt_t             xoff;
      xcnt_t             xend;
      ycnt_t             yon;
      ycnt_t             yoff;
      ycnt_t             yend;
      dcnt_t             xdil;
      dcnt_t             ydil;
      logic [ELEM_W-1:0] padval;
   } cfg_t;

   // Width of a counter that walks 0..folds-1, never below one bit.
   function automatic int fold_bits(input int folds);
      return (folds > 1) ? $clog2(folds) : 1;
   endfunction

endpackage

// File: rtl/fmpadding_axis_dim.sv
// rtl/fmpadding_axis_dim.sv - one padding axis: position and dilation counters plus shadow/active bounds
module fmpadding_axis_dim #(
   parameter int CW       = 8,
   parameter int DW       = 4,
   parameter int INIT_ON  = 1,
   parameter int INIT_OFF = 4,
   parameter int INIT_END = 5,
   parameter int INIT_DIL = 0
)(
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_step,
   input  logic          i_commit,
   input  logic          i_wr_on,
   input  logic          i_wr_off,
   input  logic          i_wr_end,
   input  logic          i_wr_dil,
   input  logic [CW-1:0] i_wd_cnt,
   input  logic [DW-1:0] i_wd_dil,
   output logic          o_is_data,
   output logic          o_at_end
);

   logic [CW-1:0] r_pos, r_on, r_off, r_end;
   logic [CW-1:0] r_sh_on, r_sh_off, r_sh_end;
   logic [DW-1:0] r_dcnt, r_dil, r_sh_dil;
   logic [CW-1:0] w_pos_nxt, w_on_nxt;
   logic [DW-1:0] w_dcnt_nxt;

   assign o_at_end  = (r_pos == r_end);
   assign o_is_data = (r_pos >= r_on) && (r_pos < r_off) && (r_dcnt == '0);

   // Next position and dilation phase; the phase restart uses the ON bound in force after this step
   always_comb begin
      w_on_nxt   = i_commit ? r_sh_on : r_on;
      w_pos_nxt  = o_at_end ? '0 : r_pos + 1'b1;
      w_dcnt_nxt = ((w_pos_nxt == w_on_nxt) || (r_dcnt == r_dil)) ? '0 : r_dcnt + 1'b1;
   end

   // Position and dilation counters advance together
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pos  <= '0;
         r_dcnt <= '0;
      end else if (i_step) begin
         r_pos  <= w_pos_nxt;
         r_dcnt <= w_dcnt_nxt;
      end
   end

   // Shadow bounds take register writes at any time
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sh_on  <= CW'(INIT_ON);
         r_sh_off <= CW'(INIT_OFF);
         r_sh_end <= CW'(INIT_END);
         r_sh_dil <= DW'(INIT_DIL);
      end else begin
         if (i_wr_on)  r_sh_on  <= i_wd_cnt;
         if (i_wr_off) r_sh_off <= i_wd_cnt;
         if (i_wr_end) r_sh_end <= i_wd_cnt;
         if (i_wr_dil) r_sh_dil <= i_wd_dil;
      end
   end

   // Active bounds only change at a frame boundary so a frame never sees a mixed config
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_on  <= CW'(INIT_ON);
         r_off <= CW'(INIT_OFF);
         r_end <= CW'(INIT_END);
         r_dil <= DW'(INIT_DIL);
      end else if (i_commit) begin
         r_on  <= r_sh_on;
         r_off <= r_sh_off;
         r_end <= r_sh_end;
         r_dil <= r_sh_dil;
      end
   end

endmodule

// File: rtl/fmpadding_dil.sv
// rtl/fmpadding_dil.sv - feature-map padding with dilation; FMPAD_TLAST_EN adds m_axis_tlast
module fmpadding_dil
   import fmpadding_pkg::*;
#(
   parameter int XCOUNTER_BITS = 8,
   parameter int YCOUNTER_BITS = 8,
   parameter int DCOUNTER_BITS = 4,
   parameter int NUM_CHANNELS  = 4,
   parameter int SIMD          = 2,
   parameter int ELEM_BITS     = 8,
   parameter int INIT_XON      = 1,
   parameter int INIT_XOFF     = 4,
   parameter int INIT_XEND     = 5,
   parameter int INIT_YON      = 1,
   parameter int INIT_YOFF     = 4,
   parameter int INIT_YEND     = 5,
   parameter int INIT_XDIL     = 0,
   parameter int INIT_YDIL     = 0,
   parameter int INIT_PADVAL   = 0,
   localparam int STREAM_BITS  = 8 * ((SIMD * ELEM_BITS + 7) / 8)
)(
   input  logic                   ap_clk,
   input  logic                   ap_rst_n,
   input  logic                   we,
   input  logic [4:0]             wa,
   input  logic [31:0]            wd,
   output logic                   s_axis_tready,
   input  logic                   s_axis_tvalid,
   input  logic [STREAM_BITS-1:0] s_axis_tdata,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tvalid,
   output logic [STREAM_BITS-1:0] m_axis_tdata
`ifdef FMPAD_TLAST_EN
   ,
   output logic                   m_axis_tlast
`endif
);

   localparam int FOLDS  = NUM_CHANNELS / SIMD;
   localparam int FOLD_W = fold_bits(FOLDS);

   logic [FOLD_W-1:0]      r_fold;
   logic [ELEM_BITS-1:0]   r_sh_padval, r_padval;
   logic                   r_valid;
   logic [STREAM_BITS-1:0] r_data;
   logic [STREAM_BITS-1:0] w_pad;
   logic w_wr_xon, w_wr_xoff, w_wr_xend, w_wr_yon, w_wr_yoff, w_wr_yend;
   logic w_wr_xdil, w_wr_ydil, w_wr_pad;
   logic w_x_data, w_x_end, w_y_data, w_y_end;
   logic w_is_data, w_fold_last, w_ld, w_fire, w_x_step, w_y_step, w_commit;
   logic w_unused_wd;

   assign w_unused_wd = ^wd;

   // Decode the config write port into one shadow-register strobe per field
   always_comb begin
      w_wr_xon  = 1'b0;
      w_wr_xoff = 1'b0;
      w_wr_xend = 1'b0;
      w_wr_yon  = 1'b0;
      w_wr_yoff = 1'b0;
      w_wr_yend = 1'b0;
      w_wr_xdil = 1'b0;
      w_wr_ydil = 1'b0;
      w_wr_pad  = 1'b0;
      if (we) begin
         case (wa)
            ADDR_XON:    w_wr_xon  = 1'b1;
            ADDR_XOFF:   w_wr_xoff = 1'b1;
            ADDR_XEND:   w_wr_xend = 1'b1;
            ADDR_YON:    w_wr_yon  = 1'b1;
            ADDR_YOFF:   w_wr_yoff = 1'b1;
            ADDR_YEND:   w_wr_yend = 1'b1;
            ADDR_XDIL:   w_wr_xdil = 1'b1;
            ADDR_YDIL:   w_wr_ydil = 1'b1;
            ADDR_PADVAL: w_wr_pad  = 1'b1;
            default:     ;
         endcase
      end
   end

   assign w_fold_last = (r_fold == FOLD_W'(FOLDS - 1));
   assign w_is_data   = w_x_data & w_y_data;
   assign w_ld        = ~r_valid | m_axis_tready;
   assign w_fire      = w_ld & (~w_is_data | s_axis_tvalid);
   assign w_x_step    = w_fire & w_fold_last;
   assign w_y_step    = w_x_step & w_x_end;
   assign w_commit    = w_y_step & w_y_end;
   assign s_axis_tready = ap_rst_n & w_ld & w_is_data;
   assign w_pad       = STREAM_BITS'({SIMD{r_padval}});

   fmpadding_axis_dim #(
      .CW(XCOUNTER_BITS), .DW(DCOUNTER_BITS),
      .INIT_ON(INIT_XON), .INIT_OFF(INIT_XOFF), .INIT_END(INIT_XEND), .INIT_DIL(INIT_XDIL)
   ) u_xdim (
      .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_step(w_x_step), .i_commit(w_commit),
      .i_wr_on(w_wr_xon), .i_wr_off(w_wr_xoff), .i_wr_end(w_wr_xend), .i_wr_dil(w_wr_xdil),
      .i_wd_cnt(wd[XCOUNTER_BITS-1:0]), .i_wd_dil(wd[DCOUNTER_BITS-1:0]),
      .o_is_data(w_x_data), .o_at_end(w_x_end)
   );

   fmpadding_axis_dim #(
      .CW(YCOUNTER_BITS), .DW(DCOUNTER_BITS),
      .INIT_ON(INIT_YON), .INIT_OFF(INIT_YOFF), .INIT_END(INIT_YEND), .INIT_DIL(INIT_YDIL)
   ) u_ydim (
      .i_clk(ap_clk), .i_rst_n(ap_rst_n), .i_step(w_y_step), .i_commit(w_commit),
      .i_wr_on(w_wr_yon), .i_wr_off(w_wr_yoff), .i_wr_end(w_wr_yend), .i_wr_dil(w_wr_ydil),
      .i_wd_cnt(wd[YCOUNTER_BITS-1:0]), .i_wd_dil(wd[DCOUNTER_BITS-1:0]),
      .o_is_data(w_y_data), .o_at_end(w_y_end)
   );

   // Fold counter is the innermost position digit
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)   r_fold <= '0;
      else if (w_fire) r_fold <= w_fold_last ? '0 : r_fold + 1'b1;
   end

   // Pad value uses the same shadow/commit scheme as the axis bounds
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_sh_padval <= ELEM_BITS'(INIT_PADVAL);
         r_padval    <= ELEM_BITS'(INIT_PADVAL);
      end else begin
         if (w_wr_pad) r_sh_padval <= wd[ELEM_BITS-1:0];
         if (w_commit) r_padval    <= r_sh_padval;
      end
   end

   // Output register: load input fold or pad fold, drop valid when drained with nothing to load
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_fire) begin
         r_valid <= 1'b1;
         r_data  <= w_is_data ? s_axis_tdata : w_pad;
      end else if (w_ld) begin
         r_valid <= 1'b0;
      end
   end

   assign m_axis_tvalid = r_valid;
   assign m_axis_tdata  = r_data;

`ifdef FMPAD_TLAST_EN
   logic r_last;

   // Last flag rides with the beat taken at the final position of the frame
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n)   r_last <= 1'b0;
      else if (w_fire) r_last <= w_fold_last & w_x_end & w_y_end;
   end

   assign m_axis_tlast = r_last;
`endif

endmodule

// File: tb/tb_fmpadding_dil.sv
// tb/tb_fmpadding_dil.sv - directed self-checking bench for fmpadding_dil
module tb_fmpadding_dil;

   localparam int SB = 16;
`ifdef FMPAD_TLAST_EN
   localparam bit TLAST_ON = 1'b1;
`else
   localparam bit TLAST_ON = 1'b0;
`endif

   typedef struct {
      int xon, xoff, xend, yon, yoff, yend, xdil, ydil, pad;
   } tcfg_t;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic          we = 1'b0;
   logic [4:0]    wa = '0;
   logic [31:0]   wd = '0;
   logic          s_axis_tready;
   logic          s_axis_tvalid = 1'b0;
   logic [SB-1:0] s_axis_tdata = '0;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tvalid;
   logic [SB-1:0] m_axis_tdata;
   logic          m_axis_tlast;

   always #5 ap_clk = ~ap_clk;

   fmpadding_dil dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .we(we), .wa(wa), .wd(wd),
      .s_axis_tready(s_axis_tready), .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
      .m_axis_tready(m_axis_tready), .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata)
`ifdef FMPAD_TLAST_EN
      , .m_axis_tlast(m_axis_tlast)
`endif
   );
`ifndef FMPAD_TLAST_EN
   assign m_axis_tlast = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   logic [SB-1:0] cap_data [0:511];
   logic          cap_last [0:511];
   int            cap_cyc  [0:511];
   logic [SB-1:0] exp_data [0:511];
   logic          exp_last [0:511];
   int exp_n, exp_in;
   int cap_n, in_cnt, stall_err, srdy_hi, wr_cyc;
   bit timed_out;
   int wq_a[$];
   int wq_d[$];
   tcfg_t c_dflt, c_dil, c_off3, c_degen;

   // Reference frame built from the plain modulo definition of a dilated data pixel
   task automatic build_exp(input tcfg_t c);
      int k, di;
      bit dx, dy;
      logic [7:0] p;
      k = 0; di = 0; p = 8'(c.pad);
      for (int y = 0; y <= c.yend; y++)
         for (int x = 0; x <= c.xend; x++)
            for (int f = 0; f < 2; f++) begin
               dx = (x >= c.xon) && (x < c.xoff) && (((x - c.xon) % (c.xdil + 1)) == 0);
               dy = (y >= c.yon) && (y < c.yoff) && (((y - c.yon) % (c.ydil + 1)) == 0);
               exp_data[k] = (dx && dy) ? SB'(16'hA000 + di) : {p, p};
               if (dx && dy) di++;
               exp_last[k] = TLAST_ON && (y == c.yend) && (x == c.xend) && (f == 1);
               k++;
            end
      exp_n = k; exp_in = di;
   endtask

   task automatic queue_cfg(input tcfg_t c);
      wq_a = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
      wq_d = '{c.xon, c.xoff, c.xend, c.yon, c.yoff, c.yend, c.xdil, c.ydil, c.pad};
   endtask

   // Drives one frame (or a prefix of it) and records accepted beats; entered and left at posedge+1
   task automatic run_frame(input int n_beats, input int n_in, input bit rnd);
      int cyc;
      bit hold;
      logic [SB-1:0] held;
      cyc = 0; cap_n = 0; in_cnt = 0; stall_err = 0; srdy_hi = 0; hold = 0; held = '0;
      while (cap_n < n_beats && cyc < 4000) begin
         s_axis_tvalid = (in_cnt < n_in) && (!rnd || ($urandom_range(0, 1) == 1));
         s_axis_tdata  = SB'(16'hA000 + in_cnt);
         m_axis_tready = !rnd || ($urandom_range(0, 1) == 1);
         we = 1'b0;
         if (cyc >= wr_cyc && wq_a.size() > 0) begin
            we = 1'b1; wa = 5'(wq_a.pop_front()); wd = 32'(wq_d.pop_front());
         end
         @(negedge ap_clk);
         if (hold && !(m_axis_tvalid === 1'b1 && m_axis_tdata === held)) stall_err++;
         hold = m_axis_tvalid && !m_axis_tready;
         held = m_axis_tdata;
         if (s_axis_tready) srdy_hi++;
         if (m_axis_tvalid && m_axis_tready) begin
            cap_data[cap_n] = m_axis_tdata; cap_last[cap_n] = m_axis_tlast; cap_cyc[cap_n] = cyc;
            cap_n++;
         end
         if (s_axis_tvalid && s_axis_tready) in_cnt++;
         @(posedge ap_clk); #1;
         cyc++;
      end
      timed_out = (cap_n < n_beats);
      s_axis_tvalid = 1'b0; m_axis_tready = 1'b0; we = 1'b0; wr_cyc = 0;
   endtask

   task automatic test_reset();
      #12;
      checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL rst_tvalid got=%b exp=0", m_axis_tvalid); end
      checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL rst_tdata got=%h exp=0000", m_axis_tdata); end
      checks++; if (s_axis_tready !== 1'b0) begin failures++; $display("FAIL rst_sready got=%b exp=0", s_axis_tready); end
      @(negedge ap_clk); ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 16'h0000) begin
         failures++; $display("FAIL rst_first_beat got=%b/%h exp=1/0000", m_axis_tvalid, m_axis_tdata);
      end
   endtask

   task automatic test_defaults();
      build_exp(c_dflt);
      queue_cfg(c_dil); wr_cyc = 5;
      run_frame(exp_n, exp_in, 1'b0);
      checks++; if (timed_out) begin failures++; $display("FAIL dflt_timeout got=%0d exp=%0d beats", cap_n, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
            failures++; $display("FAIL dflt_beat%0d got=%h/%b exp=%h/%b", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
         end
      end
      checks++; if (in_cnt !== 18) begin failures++; $display("FAIL dflt_inputs got=%0d exp=18", in_cnt); end
      checks++; if (cap_cyc[71] - cap_cyc[0] !== 71) begin failures++; $display("FAIL dflt_bubbles got=%0d exp=71 cycles", cap_cyc[71] - cap_cyc[0]); end
      checks++; if (cap_data[14] !== 16'hA000 || cap_data[8] !== 16'h0000) begin
         failures++; $display("FAIL dflt_corner got=%h/%h exp=a000/0000", cap_data[14], cap_data[8]);
      end
   endtask

   task automatic test_dilation();
      build_exp(c_dil);
      queue_cfg(c_dflt); wr_cyc = 2;
      run_frame(exp_n, exp_in, 1'b0);
      checks++; if (timed_out) begin failures++; $display("FAIL dil_timeout got=%0d exp=%0d beats", cap_n, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
            failures++; $display("FAIL dil_beat%0d got=%h/%b exp=%h/%b", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
         end
      end
      checks++; if (cap_data[0] !== 16'hA000 || cap_data[2] !== 16'h7F7F || cap_data[4] !== 16'hA002 || cap_data[10] !== 16'h7F7F) begin
         failures++; $display("FAIL dil_hand got=%h/%h/%h/%h exp=a000/7f7f/a002/7f7f", cap_data[0], cap_data[2], cap_data[4], cap_data[10]);
      end
      checks++; if (in_cnt !== 18) begin failures++; $display("FAIL dil_inputs got=%0d exp=18", in_cnt); end
   endtask

   task automatic test_random_stall();
      build_exp(c_dflt);
      wq_a = '{15}; wq_d = '{0}; wr_cyc = 3;
      run_frame(exp_n, exp_in, 1'b1);
      checks++; if (timed_out) begin failures++; $display("FAIL rnd_timeout got=%0d exp=%0d beats", cap_n, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
            failures++; $display("FAIL rnd_beat%0d got=%h/%b exp=%h/%b", k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
         end
      end
      checks++; if (stall_err !== 0) begin failures++; $display("FAIL rnd_stable got=%0d exp=0 changes", stall_err); end
      checks++; if (in_cnt !== 18) begin failures++; $display("FAIL rnd_inputs got=%0d exp=18", in_cnt); end
   endtask

   task automatic test_mid_frame_write();
      for (int fr = 0; fr < 2; fr++) begin
         if (fr == 0) begin
            build_exp(c_dflt); wq_a = '{1}; wq_d = '{3}; wr_cyc = 30;
         end else begin
            build_exp(c_off3); wq_a = '{0, 1}; wq_d = '{2, 2}; wr_cyc = 3;
         end
         run_frame(exp_n, exp_in, 1'b0);
         checks++; if (timed_out) begin failures++; $display("FAIL mid%0d_timeout got=%0d exp=%0d beats", fr, cap_n, exp_n); end
         for (int k = 0; k < exp_n; k++) begin
            checks++;
            if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
               failures++; $display("FAIL mid%0d_beat%0d got=%h/%b exp=%h/%b", fr, k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
            end
         end
      end
      checks++; if (in_cnt !== 12) begin failures++; $display("FAIL mid_inputs got=%0d exp=12", in_cnt); end
      checks++; if (cap_data[16] !== 16'hA002 || cap_data[18] !== 16'h0000) begin
         failures++; $display("FAIL mid_cols got=%h/%h exp=a002/0000", cap_data[16], cap_data[18]);
      end
   endtask

   task automatic test_degenerate();
      build_exp(c_degen);
      run_frame(exp_n, 0, 1'b0);
      checks++; if (timed_out) begin failures++; $display("FAIL degen_timeout got=%0d exp=%0d beats", cap_n, exp_n); end
      for (int k = 0; k < exp_n; k++) begin
         checks++;
         if (cap_data[k] !== 16'h0000 || cap_last[k] !== exp_last[k]) begin
            failures++; $display("FAIL degen_beat%0d got=%h/%b exp=0000/%b", k, cap_data[k], cap_last[k], exp_last[k]);
         end
      end
      checks++; if (srdy_hi !== 0 || in_cnt !== 0) begin failures++; $display("FAIL degen_sready got=%0d/%0d exp=0/0", srdy_hi, in_cnt); end
      checks++; if (cap_n !== 72) begin failures++; $display("FAIL degen_count got=%0d exp=72", cap_n); end
   endtask

   task automatic test_async_reset();
      run_frame(20, 0, 1'b0);
      checks++; if (m_axis_tvalid !== 1'b1) begin failures++; $display("FAIL arst_pre got=%b exp=1", m_axis_tvalid); end
      #2 ap_rst_n = 1'b0;
      #1;
      checks++; if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== '0 || s_axis_tready !== 1'b0) begin
         failures++; $display("FAIL arst_drop got=%b/%h/%b exp=0/0000/0", m_axis_tvalid, m_axis_tdata, s_axis_tready);
      end
      @(negedge ap_clk); @(negedge ap_clk); ap_rst_n = 1'b1;
      @(posedge ap_clk); #1;
      build_exp(c_dflt);
      for (int fr = 0; fr < 2; fr++) begin
         run_frame(exp_n, exp_in, 1'b0);
         checks++; if (timed_out) begin failures++; $display("FAIL arst%0d_timeout got=%0d exp=%0d beats", fr, cap_n, exp_n); end
         for (int k = 0; k < exp_n; k++) begin
            checks++;
            if (cap_data[k] !== exp_data[k] || cap_last[k] !== exp_last[k]) begin
               failures++; $display("FAIL arst%0d_beat%0d got=%h/%b exp=%h/%b", fr, k, cap_data[k], cap_last[k], exp_data[k], exp_last[k]);
            end
         end
         checks++; if (in_cnt !== 18) begin failures++; $display("FAIL arst%0d_inputs got=%0d exp=18", fr, in_cnt); end
      end
   endtask

   initial begin
      c_dflt  = '{1, 4, 5, 1, 4, 5, 0, 0, 0};
      c_dil   = '{0, 5, 4, 0, 5, 4, 1, 1, 8'h7F};
      c_off3  = '{1, 3, 5, 1, 4, 5, 0, 0, 0};
      c_degen = '{2, 2, 5, 1, 4, 5, 0, 0, 0};
      wr_cyc = 0;
      test_reset();
      test_defaults();
      test_dilation();
      test_random_stall();
      test_mid_frame_write();
      test_degenerate();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
